// File: rtl/queue_arbiter.sv
// Round-robin write arbiter in front of a shared circular queue.
// Tags each stored entry with its requester ID and serves the oldest entry on a valid/ready port.
module queue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_ENTRIES = 8,
  parameter int BIT_WIDTH   = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][BIT_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic                                  flush,
  input  logic                                  deq_ready,
  output logic                                  deq_valid,
  output logic [BIT_WIDTH-1:0]                  deq_data,
  output logic [$clog2(NUM_REQ)-1:0]            deq_src,
  output logic [$clog2(NUM_ENTRIES)-1:0]        wr_ptr,
  output logic [$clog2(NUM_ENTRIES)-1:0]        rd_ptr,
  output logic [$clog2(NUM_ENTRIES):0]          count,
  output logic                                  full,
  output logic                                  empty
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(NUM_ENTRIES);
  localparam logic [SRC_W:0]   NREQ     = (SRC_W+1)'(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST_REQ = SRC_W'(NUM_REQ - 1);

  logic [SRC_W+BIT_WIDTH-1:0] mem [NUM_ENTRIES];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [SRC_W-1:0] prio_q, prio_d;

  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W:0]   cand_sum;
  logic             grant_any;
  logic             grant_en;
  logic             push;
  logic             pop;

  // Scan from the far end of the search order so the last hit is the first in priority order.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, prio_q} + (SRC_W+1)'(k);
      if (cand_sum >= NREQ) cand_sum = cand_sum - NREQ;
      if (req_valid[cand_sum[SRC_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    grant_en  = reset && (count_q != FULL_CNT) && !flush;
    push      = grant_en && grant_any;
    pop       = !flush && (count_q != '0) && deq_ready;
    req_ready = '0;
    if (push) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        prio_d   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
    end
  end

  // Payload storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {grant_idx, req_data[grant_idx]};
  end

  assign deq_valid             = (count_q != '0);
  assign {deq_src, deq_data}   = mem[rd_ptr_q];
  assign wr_ptr                = wr_ptr_q;
  assign rd_ptr                = rd_ptr_q;
  assign count                 = count_q;
  assign full                  = (count_q == FULL_CNT);
  assign empty                 = (count_q == '0);

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter: a reference model predicts grants and occupancy,
// and a scoreboard queue of {src,data} checks every head entry the DUT presents.
module tb_queue_arbiter;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready;
  logic             flush;
  logic             deq_ready;
  logic             deq_valid;
  logic [7:0]       deq_data;
  logic [1:0]       deq_src;
  logic [2:0]       wr_ptr;
  logic [2:0]       rd_ptr;
  logic [3:0]       count;
  logic             full;
  logic             empty;

  int tests = 0;
  int fails = 0;
  int step_no = 0;

  logic [9:0] sb [$];
  logic [2:0] m_wr;
  logic [2:0] m_rd;
  int         m_prio;

  queue_arbiter #(.NUM_REQ(4), .NUM_ENTRIES(8), .BIT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_data(deq_data), .deq_src(deq_src),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against model, then advance model at the edge.
  task automatic step(input logic [3:0] v, input logic dr, input logic fl);
    logic [3:0] exp_rdy;
    int g;
    int popped;
    req_valid = v;
    deq_ready = dr;
    flush     = fl;
    for (int i = 0; i < 4; i++) req_data[i] = 8'(step_no * 16 + i * 5 + 1);
    #1;
    exp_rdy = 4'b0;
    g = -1;
    if (!fl && sb.size() < 8) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_prio + k) % 4;
        if (v[c] && g < 0) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("deq_valid", 32'(deq_valid), 32'(sb.size() != 0));
    chk("count", 32'(count), 32'(sb.size()));
    chk("full", 32'(full), 32'(sb.size() == 8));
    chk("empty", 32'(empty), 32'(sb.size() == 0));
    chk("wr_ptr", 32'(wr_ptr), 32'(m_wr));
    chk("rd_ptr", 32'(rd_ptr), 32'(m_rd));
    if (sb.size() != 0) begin
      chk("deq_src", 32'(deq_src), 32'(sb[0][9:8]));
      chk("deq_data", 32'(deq_data), 32'(sb[0][7:0]));
    end
    @(posedge clk);
    popped = 0;
    if (fl) begin
      sb.delete();
      m_wr = 3'd0;
      m_rd = 3'd0;
    end else begin
      if (dr && sb.size() != 0) begin
        void'(sb.pop_front());
        m_rd = m_rd + 3'd1;
        popped = 1;
      end
      if (g >= 0) begin
        sb.push_back({2'(g), req_data[g]});
        m_wr = m_wr + 3'd1;
        m_prio = (g + 1) % 4;
      end
    end
    $display("[TB] step %0d valid=%b flush=%0d grant=%0d pop=%0d count=%0d",
             step_no, v, fl, g, popped, sb.size());
    step_no++;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = 4'b1111;
    deq_ready = 1'b0;
    flush = 1'b0;
    req_data = '0;
    m_wr = 3'd0;
    m_rd = 3'd0;
    m_prio = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_ptrs", 32'({wr_ptr, rd_ptr}), 32'h0);
    reset = 1'b1;

    // Fill: grants rotate 0,1,2,3,0,1,2,3 then stall at full.
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 1'b0, 1'b0);
    end
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_count", 32'(count), 32'h8);
    step(4'b1111, 1'b0, 1'b0);

    // Drain with no requests; source order must follow grant order.
    for (int k = 0; k < 8; k++) begin
      chk("drain_src_order", 32'(deq_src), 32'(k % 4));
      step(4'b0000, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 32'h1);
    chk("drain_rd_wrap", 32'(rd_ptr), 32'h0);

    // Single requester 2 with pops enabled; each word drains the cycle after its write.
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b1, 1'b0);
    end
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Steady state at count=3 with simultaneous push and pop.
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b1111, 1'b1, 1'b0);
    chk("steady_count", 32'(count), 32'h3);

    // Reach count=5, flush with a request and pop pending.
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count), 32'h5);
    step(4'b0100, 1'b1, 1'b1);
    chk("post_flush_count", 32'(count), 32'h0);
    chk("post_flush_ptrs", 32'({wr_ptr, rd_ptr}), 32'h0);
    step(4'b0100, 1'b0, 1'b0);

    // Build count=6 with prio=3, then reset asynchronously mid-stream.
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'h6);
    req_valid = 4'b1111;
    reset = 1'b0;
    #1;
    chk("midrst_deq_valid", 32'(deq_valid), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    m_wr = 3'd0;
    m_rd = 3'd0;
    m_prio = 0;
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'h1);
    step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
